// File: rtl/apb_master_param_if.sv
// ---------------------------------------------------------------------------
// apb_master_param_if
// APB bus bundle between apb_master_param and its slaves.
//   psel     one-hot slave select (NUM_SLAVES bits)   master -> slave
//   penable  access phase strobe                      master -> slave
//   pwrite   1 = write, 0 = read                      master -> slave
//   paddr    transfer address (ADDR_W)                master -> slave
//   pwdata   write data (DATA_W)                      master -> slave
//   prdata   read data (DATA_W)                       slave  -> master
//   pready   slave ready, ends the access phase       slave  -> master
//   pslverr  slave error, valid with pready           slave  -> master
// ---------------------------------------------------------------------------
interface apb_master_param_if #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 2
) ();
   logic [NUM_SLAVES-1:0] psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [DATA_W-1:0]     prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_master_param.sv
// ---------------------------------------------------------------------------
// apb_master_param
// Processor-to-APB bridge with a one-entry pending command buffer and an
// optional access-phase timeout.
//   clk       sole clock, rising edge
//   reset     asynchronous, active-low reset
//   p_start   request strobe (p_write, p_addr, p_wdata, p_sel sampled with it)
//   p_rdata   read data of the last completed read
//   p_stable  one-cycle completion pulse, p_err valid with it
//   p_busy    transfer in flight or pending buffer occupied
//   p_ovf     sticky: a request was dropped because the buffer was full
//   apb       APB master side (psel/penable/pwrite/paddr/pwdata out,
//             prdata/pready/pslverr in)
// ---------------------------------------------------------------------------
module apb_master_param #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 2,
   parameter int TIMEOUT    = 16,
   localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               p_start,
   input  logic               p_write,
   input  logic [ADDR_W-1:0]  p_addr,
   input  logic [DATA_W-1:0]  p_wdata,
   input  logic [SEL_W-1:0]   p_sel,
   output logic [DATA_W-1:0]  p_rdata,
   output logic               p_stable,
   output logic               p_err,
   output logic               p_busy,
   output logic               p_ovf,
   apb_master_param_if.master apb
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Counter value seen on the last permitted waiting cycle.
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                state_reg;
   logic [CNT_W-1:0]      wait_cnt_reg;

   // The APB drive registers double as the latched command of the
   // transfer in flight.
   logic [NUM_SLAVES-1:0] psel_reg;
   logic                  penable_reg;
   logic                  pwrite_reg;
   logic [ADDR_W-1:0]     paddr_reg;
   logic [DATA_W-1:0]     pwdata_reg;

   logic                  buf_valid_reg;
   logic                  buf_write_reg;
   logic [ADDR_W-1:0]     buf_addr_reg;
   logic [DATA_W-1:0]     buf_wdata_reg;
   logic [SEL_W-1:0]      buf_sel_reg;

   logic [DATA_W-1:0]     p_rdata_reg;
   logic                  p_stable_reg;
   logic                  p_err_reg;
   logic                  p_ovf_reg;

   // Next command to launch: the buffered one has priority over a new strobe.
   logic                  nxt_write;
   logic [ADDR_W-1:0]     nxt_addr;
   logic [DATA_W-1:0]     nxt_wdata;
   logic [SEL_W-1:0]      nxt_sel;
   logic [NUM_SLAVES-1:0] nxt_onehot;
   logic                  nxt_sel_ok;

   logic                  complete;
   logic                  complete_err;

   assign nxt_write = buf_valid_reg ? buf_write_reg : p_write;
   assign nxt_addr  = buf_valid_reg ? buf_addr_reg  : p_addr;
   assign nxt_wdata = buf_valid_reg ? buf_wdata_reg : p_wdata;
   assign nxt_sel   = buf_valid_reg ? buf_sel_reg   : p_sel;

   // Out-of-range indices decode to all zeros, which marks the command invalid.
   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel_dec
      assign nxt_onehot[gi] = (int'(nxt_sel) == gi);
   end
   assign nxt_sel_ok = |nxt_onehot;

   always_comb begin
      complete     = 1'b0;
      complete_err = 1'b0;
      case (state_reg)
         // SETUP with no select only happens for an invalid command launched
         // straight from a completion; it finishes here with an error.
         SETUP: begin
            if (psel_reg == '0) begin
               complete     = 1'b1;
               complete_err = 1'b1;
            end
         end
         ACCESS: begin
            if (apb.pready) begin
               complete     = 1'b1;
               complete_err = apb.pslverr;
            end else if ((TIMEOUT > 0) && (wait_cnt_reg == TO_LAST)) begin
               complete     = 1'b1;
               complete_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         wait_cnt_reg  <= '0;
         psel_reg      <= '0;
         penable_reg   <= 1'b0;
         pwrite_reg    <= 1'b0;
         paddr_reg     <= '0;
         pwdata_reg    <= '0;
         buf_valid_reg <= 1'b0;
         buf_write_reg <= 1'b0;
         buf_addr_reg  <= '0;
         buf_wdata_reg <= '0;
         buf_sel_reg   <= '0;
         p_rdata_reg   <= '0;
         p_stable_reg  <= 1'b0;
         p_err_reg     <= 1'b0;
         p_ovf_reg     <= 1'b0;
      end else begin
         p_stable_reg <= 1'b0;

         if (complete) begin
            p_stable_reg <= 1'b1;
            p_err_reg    <= complete_err;
            if ((state_reg == ACCESS) && apb.pready && !pwrite_reg) begin
               p_rdata_reg <= apb.prdata;
            end
            psel_reg    <= '0;
            penable_reg <= 1'b0;

            // The buffer frees on this edge, but a strobe arriving while it
            // is still full is dropped.
            if (buf_valid_reg) begin
               buf_valid_reg <= 1'b0;
               if (p_start) begin
                  p_ovf_reg <= 1'b1;
               end
            end

            // Chain straight into SETUP; an empty buffer plus a coincident
            // strobe passes the new command through without an IDLE cycle.
            if (buf_valid_reg || p_start) begin
               pwrite_reg <= nxt_write;
               paddr_reg  <= nxt_addr;
               pwdata_reg <= nxt_wdata;
               psel_reg   <= nxt_onehot;
               state_reg  <= SETUP;
            end else begin
               state_reg  <= IDLE;
            end
         end else begin
            case (state_reg)
               IDLE: begin
                  if (p_start) begin
                     if (nxt_sel_ok) begin
                        pwrite_reg <= nxt_write;
                        paddr_reg  <= nxt_addr;
                        pwdata_reg <= nxt_wdata;
                        psel_reg   <= nxt_onehot;
                        state_reg  <= SETUP;
                     end else begin
                        // No slave to address: report the error immediately.
                        p_stable_reg <= 1'b1;
                        p_err_reg    <= 1'b1;
                     end
                  end
               end
               SETUP: begin
                  penable_reg  <= 1'b1;
                  wait_cnt_reg <= '0;
                  state_reg    <= ACCESS;
               end
               ACCESS: begin
                  wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase

            if ((state_reg != IDLE) && p_start) begin
               if (!buf_valid_reg) begin
                  buf_valid_reg <= 1'b1;
                  buf_write_reg <= p_write;
                  buf_addr_reg  <= p_addr;
                  buf_wdata_reg <= p_wdata;
                  buf_sel_reg   <= p_sel;
               end else begin
                  p_ovf_reg <= 1'b1;
               end
            end
         end
      end
   end

   assign apb.psel    = psel_reg;
   assign apb.penable = penable_reg;
   assign apb.pwrite  = pwrite_reg;
   assign apb.paddr   = paddr_reg;
   assign apb.pwdata  = pwdata_reg;

   assign p_rdata  = p_rdata_reg;
   assign p_stable = p_stable_reg;
   assign p_err    = p_err_reg;
   assign p_ovf    = p_ovf_reg;
   assign p_busy   = (state_reg != IDLE) || buf_valid_reg;

endmodule

// File: tb/tb_apb_master_param.sv
// ---------------------------------------------------------------------------
// tb_apb_master_param
// Directed bench for apb_master_param. Expected completions are queued when
// a request is issued; a monitor pops them on every p_stable pulse. A small
// slave model answers after a programmable number of wait states.
// Three slaves are used: with two, the 1-bit select cannot encode an
// out-of-range index, so the invalid-select case would be unreachable.
// ---------------------------------------------------------------------------
module tb_apb_master_param;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int NSL    = 3;
   localparam int SEL_W  = 2;

   typedef struct packed {
      logic       err;
      logic [7:0] rdata;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              p_start = 1'b0;
   logic              p_write = 1'b0;
   logic [ADDR_W-1:0] p_addr = '0;
   logic [DATA_W-1:0] p_wdata = '0;
   logic [SEL_W-1:0]  p_sel = '0;
   logic [DATA_W-1:0] p_rdata;
   logic              p_stable;
   logic              p_err;
   logic              p_busy;
   logic              p_ovf;

   apb_master_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NSL)) apb_bus ();

   apb_master_param #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NSL), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset), .p_start(p_start), .p_write(p_write),
      .p_addr(p_addr), .p_wdata(p_wdata), .p_sel(p_sel), .p_rdata(p_rdata),
      .p_stable(p_stable), .p_err(p_err), .p_busy(p_busy), .p_ovf(p_ovf),
      .apb(apb_bus)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   // Slave model controls and bus observation counters.
   int         wait_states = 0;
   logic [7:0] rd_value = 8'h00;
   logic       slv_err = 1'b0;
   int         cyc = 0;
   int         start_cyc = 0;
   int         stable_cyc = 0;
   int         stable_cnt = 0;
   int         setup_cnt = 0;
   int         access_cnt = 0;
   int         b2b_cnt = 0;
   logic [2:0] psel_or = '0;
   logic       prev_penable = 1'b0;
   logic [7:0] last_addr = '0;
   logic [7:0] last_wdata = '0;
   logic       last_write = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic clear_counters();
      stable_cnt = 0; setup_cnt = 0; access_cnt = 0; b2b_cnt = 0; psel_or = '0;
   endtask

   task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [SEL_W-1:0] s);
      @(posedge clk); #1;
      p_start = 1'b1; p_write = w; p_addr = a; p_wdata = d; p_sel = s;
      start_cyc = cyc;
      @(posedge clk); #1;
      p_start = 1'b0;
   endtask

   task automatic push_exp(input logic e, input logic [7:0] r);
      exp_t x;
      x.err = e; x.rdata = r;
      exp_q.push_back(x);
   endtask

   task automatic wait_stable(input string name, input int target, input int budget);
      int n = 0;
      while (stable_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(stable_cnt >= target), 64'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Slave model: pready rises after wait_states access cycles.
   initial begin : slave
      int k;
      k = 0;
      apb_bus.pready = 1'b0; apb_bus.pslverr = 1'b0; apb_bus.prdata = '0;
      forever begin
         @(negedge clk);
         apb_bus.prdata  = rd_value;
         apb_bus.pslverr = slv_err;
         if (apb_bus.penable) begin
            apb_bus.pready = (k >= wait_states);
            k++;
         end else begin
            apb_bus.pready = 1'b0;
            k = 0;
         end
      end
   end

   // Bus observer and completion scoreboard.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (apb_bus.psel != '0 && !apb_bus.penable) begin
            setup_cnt++;
            if (prev_penable) b2b_cnt++;
         end
         if (apb_bus.penable) begin
            access_cnt++;
            last_addr = apb_bus.paddr; last_wdata = apb_bus.pwdata; last_write = apb_bus.pwrite;
         end
         psel_or = psel_or | apb_bus.psel;
         prev_penable = apb_bus.penable;
         if (p_stable) begin
            stable_cnt++;
            stable_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_stable: got err=%0b rdata=0x%02h, required no completion",
                        p_err, p_rdata);
            end else begin
               e = exp_q.pop_front();
               if (p_err !== e.err || p_rdata !== e.rdata) begin
                  errors++;
                  $display("FAIL completion: got err=%0b rdata=0x%02h, required err=%0b rdata=0x%02h",
                           p_err, p_rdata, e.err, e.rdata);
               end else begin
                  $display("txn at cycle %0d: err=%0b rdata=0x%02h", cyc, p_err, p_rdata);
               end
            end
         end
      end
   end

   initial begin : stim
      // Reset state
      idle(3);
      check("reset_outputs", {apb_bus.psel, apb_bus.penable, apb_bus.pwrite, apb_bus.paddr,
                              apb_bus.pwdata, p_rdata, p_stable, p_err, p_busy, p_ovf}, 64'd0);
      @(posedge clk); #1 reset = 1'b1;
      idle(2);

      // Single write, zero wait states, minimum latency
      clear_counters();
      push_exp(1'b0, 8'h00);
      issue(1'b1, 8'h05, 8'h04, 2'd1);
      wait_stable("wr_done", 1, 20);
      idle(2);
      check("wr_latency", 64'(stable_cyc - start_cyc), 64'd4);
      check("wr_setup", 64'(setup_cnt), 64'd1);
      check("wr_access", 64'(access_cnt), 64'd1);
      check("wr_psel", 64'(psel_or), 64'b010);
      check("wr_bus", {last_write, last_addr, last_wdata}, {1'b1, 8'h05, 8'h04});

      // Slave error reported on a write
      clear_counters();
      slv_err = 1'b1;
      push_exp(1'b1, 8'h00);
      issue(1'b1, 8'h33, 8'h5A, 2'd2);
      wait_stable("slverr_done", 1, 20);
      slv_err = 1'b0;
      idle(2);
      check("slverr_psel", 64'(psel_or), 64'b100);

      // Read with five wait states
      clear_counters();
      wait_states = 5; rd_value = 8'h06;
      push_exp(1'b0, 8'h06);
      issue(1'b0, 8'h06, 8'h00, 2'd0);
      wait_stable("rd_done", 1, 30);
      idle(2);
      check("rd_access", 64'(access_cnt), 64'd6);
      check("rd_bus", {last_write, last_addr}, {1'b0, 8'h06});
      check("rd_psel", 64'(psel_or), 64'b001);

      // Back-to-back: second request buffered during ACCESS
      clear_counters();
      wait_states = 2; rd_value = 8'h3C;
      push_exp(1'b0, 8'h06);
      issue(1'b1, 8'h10, 8'hA5, 2'd0);
      push_exp(1'b0, 8'h3C);
      issue(1'b0, 8'h11, 8'h00, 2'd1);
      @(negedge clk);
      check("b2b_busy", 64'(p_busy), 64'd1);
      wait_stable("b2b_done", 2, 40);
      idle(3);
      check("b2b_setup", 64'(setup_cnt), 64'd2);
      check("b2b_nogap", 64'(b2b_cnt), 64'd1);
      check("b2b_access", 64'(access_cnt), 64'd6);
      check("b2b_psel", 64'(psel_or), 64'b011);

      // Timeout with pready held low
      clear_counters();
      wait_states = 1000; rd_value = 8'h77;
      push_exp(1'b1, 8'h3C);
      issue(1'b0, 8'h40, 8'h00, 2'd2);
      wait_stable("to_done", 1, 40);
      check("to_access", 64'(access_cnt), 64'd16);
      check("to_bus_idle", {apb_bus.psel, apb_bus.penable, p_busy}, 64'd0);
      idle(2);

      // Buffer overflow: third request dropped
      clear_counters();
      wait_states = 4;
      push_exp(1'b0, 8'h3C);
      issue(1'b1, 8'h50, 8'h11, 2'd0);
      push_exp(1'b0, 8'h3C);
      issue(1'b1, 8'h51, 8'h22, 2'd1);
      issue(1'b1, 8'h52, 8'h33, 2'd2);
      @(negedge clk);
      check("ovf_set", 64'(p_ovf), 64'd1);
      wait_stable("ovf_done", 2, 60);
      idle(20);
      check("ovf_stables", 64'(stable_cnt), 64'd2);
      check("ovf_setup", 64'(setup_cnt), 64'd2);
      check("ovf_psel", 64'(psel_or), 64'b011);
      check("ovf_last_wdata", 64'(last_wdata), 64'h22);

      // Out-of-range select: no APB phases, error completion
      clear_counters();
      wait_states = 0;
      push_exp(1'b1, 8'h3C);
      issue(1'b1, 8'h60, 8'h44, 2'd3);
      wait_stable("badsel_done", 1, 10);
      idle(3);
      check("badsel_psel", 64'(psel_or), 64'd0);
      check("badsel_phases", 64'(setup_cnt + access_cnt), 64'd0);
      check("ovf_sticky", 64'(p_ovf), 64'd1);

      // Asynchronous reset during ACCESS
      wait_states = 1000;
      issue(1'b0, 8'h70, 8'h00, 2'd1);
      begin
         int n = 0;
         while (!apb_bus.penable && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("rst_reach_access", 64'(apb_bus.penable), 64'd1);
      end
      #2 reset = 1'b0;
      #1;
      check("rst_async_outputs", {apb_bus.psel, apb_bus.penable, apb_bus.pwrite, apb_bus.paddr,
                                  apb_bus.pwdata, p_rdata, p_stable, p_err, p_busy, p_ovf}, 64'd0);
      @(posedge clk); #1 reset = 1'b1;
      clear_counters();
      idle(10);
      check("rst_no_stable", 64'(stable_cnt), 64'd0);
      wait_states = 0;
      push_exp(1'b0, 8'h00);
      issue(1'b1, 8'h22, 8'h99, 2'd2);
      wait_stable("rst_next_done", 1, 20);
      idle(2);
      check("rst_next_setup", 64'(setup_cnt), 64'd1);
      check("rst_next_psel", 64'(psel_or), 64'b100);
      check("rst_next_bus", {last_write, last_addr, last_wdata}, {1'b1, 8'h22, 8'h99});

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
